// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Writeback stage and integer register file for a five-stage pipeline.
//   Selects the writeback value from the MEM/WB stage register, commits it
//   into one of 32 x 32-bit registers, and serves two ID-stage read ports
//   with write-first bypass plus one unbypassed debug read port. A
//   saturating counter tracks how many register writes have been committed.
//
//   Ports
//     clk_i         clock; all state changes on its rising edge
//     rst_i         asynchronous, active-low reset (clears registers and counter)
//     regwrite_i    writeback enable from MEM/WB
//     memtoreg_i    writeback source: 1 = memdata_i, 0 = alu_result_i
//     alu_result_i  ALU result from MEM/WB
//     memdata_i     load data from MEM/WB
//     rd_addr_i     destination register index
//     rs1_addr_i    read port 1 index
//     rs2_addr_i    read port 2 index
//     rs1_data_o    read port 1 data (bypassed)
//     rs2_data_o    read port 2 data (bypassed)
//     dbg_addr_i    debug read index
//     dbg_data_o    debug read data (stored value only)
//     wb_data_o     selected writeback value
//     wb_count_o    saturating count of committed register writes
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             regwrite_i,
  input  logic             memtoreg_i,
  input  logic [31:0]      alu_result_i,
  input  logic [31:0]      memdata_i,
  input  logic [4:0]       rd_addr_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  output logic [31:0]      rs1_data_o,
  output logic [31:0]      rs2_data_o,
  input  logic [4:0]       dbg_addr_i,
  output logic [31:0]      dbg_data_o,
  output logic [31:0]      wb_data_o,
  output logic [CNT_W-1:0] wb_count_o
);

  logic [31:0]      regs_q [0:31];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             commit;

  assign wb_data_o = memtoreg_i ? memdata_i : alu_result_i;

  // Writes to x0 are discarded, so they neither change storage nor count.
  assign commit = regwrite_i && (rd_addr_i != 5'd0);

  // NOTE: every register, including the storage array, is cleared by the
  // asynchronous reset because software may read any index right after reset
  // and expects zero; this costs a reset pin per flop instead of using a RAM.
  // NOTE: sequential state is only ever assigned with <= so that every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else if (commit) begin
      regs_q[rd_addr_i] <= wb_data_o;
    end
  end

  // Saturate rather than wrap so a large count is never mistaken for a small one.
  // NOTE: cnt_d gets a default before any condition so the block can never
  // infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (commit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wb_count_o = cnt_q;

  // Read ports: x0 is hard-wired to zero; otherwise a same-cycle write to the
  // requested index is forwarded so ID sees the value WB is about to commit.
  // commit already excludes rd=0, so the bypass can never hit x0.
  always_comb begin
    rs1_data_o = (rs1_addr_i == 5'd0) ? 32'h0 : regs_q[rs1_addr_i];
    if (commit && (rd_addr_i == rs1_addr_i)) begin
      rs1_data_o = wb_data_o;
    end
  end

  always_comb begin
    rs2_data_o = (rs2_addr_i == 5'd0) ? 32'h0 : regs_q[rs2_addr_i];
    if (commit && (rd_addr_i == rs2_addr_i)) begin
      rs2_data_o = wb_data_o;
    end
  end

  // Debug port shows only what has actually been stored.
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? 32'h0 : regs_q[dbg_addr_i];

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Directed self-checking bench for wb_regfile. Two instances share every
//   input: one with the default 16-bit counter and one with a 4-bit counter
//   so saturation can be exercised. Inputs change on the falling edge and
//   outputs are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        regwrite_i;
  logic        memtoreg_i;
  logic [31:0] alu_result_i;
  logic [31:0] memdata_i;
  logic [4:0]  rd_addr_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [4:0]  dbg_addr_i;

  logic [31:0] rs1_data_o,  rs2_data_o,  dbg_data_o,  wb_data_o;
  logic [15:0] wb_count_o;
  logic [31:0] rs1_data_c4, rs2_data_c4, dbg_data_c4, wb_data_c4;
  logic [3:0]  wb_count_c4;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  wb_regfile dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .regwrite_i   (regwrite_i),
    .memtoreg_i   (memtoreg_i),
    .alu_result_i (alu_result_i),
    .memdata_i    (memdata_i),
    .rd_addr_i    (rd_addr_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs2_addr_i   (rs2_addr_i),
    .rs1_data_o   (rs1_data_o),
    .rs2_data_o   (rs2_data_o),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_data_o   (dbg_data_o),
    .wb_data_o    (wb_data_o),
    .wb_count_o   (wb_count_o)
  );

  wb_regfile #(.CNT_W(4)) dut_c4 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .regwrite_i   (regwrite_i),
    .memtoreg_i   (memtoreg_i),
    .alu_result_i (alu_result_i),
    .memdata_i    (memdata_i),
    .rd_addr_i    (rd_addr_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs2_addr_i   (rs2_addr_i),
    .rs1_data_o   (rs1_data_c4),
    .rs2_data_o   (rs2_data_c4),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_data_o   (dbg_data_c4),
    .wb_data_o    (wb_data_c4),
    .wb_count_o   (wb_count_c4)
  );

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %08h, expected %08h", tag, actual, expected);
    end
  endtask

  // Present one writeback transaction (inputs only; caller clocks it).
  task automatic drive_wb(input logic we, input logic m2r, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [4:0] rd);
    regwrite_i   = we;
    memtoreg_i   = m2r;
    alu_result_i = alu;
    memdata_i    = mem;
    rd_addr_i    = rd;
  endtask

  task automatic idle();
    drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i      = 1'b0;
    rs1_addr_i = 5'd0;
    rs2_addr_i = 5'd0;
    dbg_addr_i = 5'd0;
    idle();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1;

    // Reset state: every register reads zero, counters zero.
    for (int i = 0; i < 32; i++) begin
      dbg_addr_i = 5'(i);
      #1;
      check($sformatf("reset_dbg_x%0d", i), dbg_data_o, 32'h0);
    end
    check("reset_cnt16", 32'(wb_count_o), 32'd0);
    check("reset_cnt4",  32'(wb_count_c4), 32'd0);

    // ALU writeback to x5 with same-cycle bypass on rs1.
    @(negedge clk_i);
    drive_wb(1'b1, 1'b0, 32'hDEADBEEF, 32'h0BADF00D, 5'd5);
    rs1_addr_i = 5'd5;
    rs2_addr_i = 5'd6;
    dbg_addr_i = 5'd5;
    #1;
    check("x5_wb_data",    wb_data_o,  32'hDEADBEEF);
    check("x5_rs1_bypass", rs1_data_o, 32'hDEADBEEF);
    check("x5_rs2_other",  rs2_data_o, 32'h0);
    check("x5_dbg_before", dbg_data_o, 32'h0);
    next_cycle();
    idle();
    #1;
    check("x5_dbg_after",  dbg_data_o, 32'hDEADBEEF);
    check("x5_rs1_stored", rs1_data_o, 32'hDEADBEEF);
    check("x5_cnt16",      32'(wb_count_o), 32'd1);
    check("x5_cnt4",       32'(wb_count_c4), 32'd1);

    // Load writeback to x7, both read ports bypassed together.
    drive_wb(1'b1, 1'b1, 32'hFFFFFFFF, 32'h12345678, 5'd7);
    rs1_addr_i = 5'd7;
    rs2_addr_i = 5'd7;
    dbg_addr_i = 5'd7;
    #1;
    check("x7_wb_data",    wb_data_o,  32'h12345678);
    check("x7_rs1_bypass", rs1_data_o, 32'h12345678);
    check("x7_rs2_bypass", rs2_data_o, 32'h12345678);
    next_cycle();
    idle();
    #1;
    check("x7_dbg_after",  dbg_data_o, 32'h12345678);
    check("x7_cnt16",      32'(wb_count_o), 32'd2);

    // regwrite=0: no bypass, no storage change, no count.
    drive_wb(1'b0, 1'b1, 32'h11111111, 32'h22222222, 5'd5);
    rs1_addr_i = 5'd5;
    dbg_addr_i = 5'd5;
    #1;
    check("nowe_rs1",      rs1_data_o, 32'hDEADBEEF);
    next_cycle();
    #1;
    check("nowe_dbg",      dbg_data_o, 32'hDEADBEEF);
    check("nowe_cnt16",    32'(wb_count_o), 32'd2);

    // Write to x0 is a no-op on every port.
    drive_wb(1'b1, 1'b0, 32'hAAAAAAAA, 32'h0, 5'd0);
    rs1_addr_i = 5'd0;
    rs2_addr_i = 5'd0;
    dbg_addr_i = 5'd0;
    #1;
    check("x0_rs1",        rs1_data_o, 32'h0);
    check("x0_rs2",        rs2_data_o, 32'h0);
    next_cycle();
    idle();
    #1;
    check("x0_dbg",        dbg_data_o, 32'h0);
    check("x0_cnt16",      32'(wb_count_o), 32'd2);
    check("x0_cnt4",       32'(wb_count_c4), 32'd2);

    // 20 writes x1..x20: 4-bit counter saturates at F, 16-bit reaches 22.
    for (int i = 1; i <= 20; i++) begin
      drive_wb(1'b1, 1'b0, 32'h100 + 32'(i), 32'h0, 5'(i));
      next_cycle();
      if (i == 12) begin
        #1;
        check("sat_cnt4_mid", 32'(wb_count_c4), 32'd14);
      end
    end
    idle();
    #1;
    check("sat_cnt4",      32'(wb_count_c4), 32'hF);
    check("sat_cnt16",     32'(wb_count_o), 32'd22);
    dbg_addr_i = 5'd20;
    #1;
    check("sat_dbg_x20",   dbg_data_o, 32'h114);
    dbg_addr_i = 5'd5;
    #1;
    check("sat_dbg_x5",    dbg_data_c4, 32'h105);
    drive_wb(1'b1, 1'b0, 32'h0000_0155, 32'h0, 5'd21);
    next_cycle();
    idle();
    #1;
    check("sat_cnt4_hold", 32'(wb_count_c4), 32'hF);

    // Write x3=0x55, then reset mid-cycle.
    drive_wb(1'b1, 1'b0, 32'h55, 32'h0, 5'd3);
    next_cycle();
    idle();
    dbg_addr_i = 5'd3;
    rs1_addr_i = 5'd3;
    #1;
    check("rst_pre_x3",    dbg_data_o, 32'h55);
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_dbg_x3",    dbg_data_o, 32'h0);
    check("rst_rs1_x3",    rs1_data_o, 32'h0);
    check("rst_cnt16",     32'(wb_count_o), 32'd0);
    check("rst_cnt4",      32'(wb_count_c4), 32'd0);
    // A write presented across a rising edge while in reset is ignored.
    rs1_addr_i = 5'd4;
    drive_wb(1'b1, 1'b0, 32'h77, 32'h0, 5'd3);
    next_cycle();
    idle();
    #1;
    check("rst_ignore_dbg", dbg_data_o, 32'h0);
    check("rst_ignore_cnt", 32'(wb_count_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    drive_wb(1'b1, 1'b0, 32'h66, 32'h0, 5'd3);
    next_cycle();
    idle();
    #1;
    check("post_rst_x3",   dbg_data_o, 32'h66);
    check("post_rst_cnt",  32'(wb_count_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
